// File: rtl/encrypt_pipe_pkg.sv
// Shared PRESENT-80 parameters and combinational helpers.
// S-box, permutation layers and key-schedule update.
package encrypt_pipe_pkg;

   localparam int N_K = 80;
   localparam int N_B = 64;
   localparam int N_R = 31;

   // Nibble i of the table holds S[i]
   localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TBL[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [N_B-1:0] s_layer(input logic [N_B-1:0] s);
      logic [N_B-1:0] o;
      o = '0;
      for (int i = 0; i < N_B / 4; i++) begin
         o[4*i +: 4] = sbox(s[4*i +: 4]);
      end
      return o;
   endfunction

   function automatic logic [N_B-1:0] p_layer(input logic [N_B-1:0] s);
      logic [N_B-1:0] o;
      o = '0;
      for (int i = 0; i < N_B - 1; i++) begin
         o[(16 * i) % 63] = s[i];
      end
      o[N_B-1] = s[N_B-1];
      return o;
   endfunction

   function automatic logic [N_K-1:0] key_update(
      input logic [N_K-1:0] kin,
      input logic [4:0]     rc
   );
      logic [N_K-1:0] t;
      t          = {kin[18:0], kin[79:19]};
      t[79:76]   = sbox(t[79:76]);
      t[19:15]   = t[19:15] ^ rc;
      return t;
   endfunction

endpackage

// File: rtl/present_round.sv
// One PRESENT-80 round plus the matching key-schedule step.
// Purely combinational; the round index is an elaboration constant.
module present_round
   import encrypt_pipe_pkg::*;
#(
   parameter logic [4:0] RND = 5'd1
) (
   input  logic [N_B-1:0] state_i,
   input  logic [N_K-1:0] key_i,
   output logic [N_B-1:0] state_o,
   output logic [N_K-1:0] key_o
);

   logic [N_B-1:0] mixed;

   assign mixed   = state_i ^ key_i[N_K-1:N_K-N_B];
   assign state_o = p_layer(s_layer(mixed));
   assign key_o   = key_update(key_i, RND);

endmodule

// File: rtl/encrypt_pipe.sv
// Fully pipelined PRESENT-80 encryption, one block per clock.
// Key schedule travels with each block; output held at 0 until real data lands.
module encrypt_pipe
   import encrypt_pipe_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [N_K-1:0] k,
   input  logic [N_B-1:0] m,
   output logic [N_B-1:0] c
);

   logic [N_B-1:0] state_q [N_R+1];
   logic [N_B-1:0] state_d [N_R+1];
   logic [N_K-1:0] key_q   [N_R+1];
   logic [N_K-1:0] key_d   [N_R+1];
   logic [N_R:0]   vld_q;
   logic [N_R:0]   vld_d;

   assign state_d[0] = m;
   assign key_d[0]   = k;

   // Tracks which stages hold captured data rather than reset fill
   assign vld_d = {vld_q[N_R-1:0], 1'b1};

   for (genvar r = 1; r <= N_R; r++) begin : g_rnd
      present_round #(
         .RND (5'(r))
      ) u_rnd (
         .state_i (state_q[r-1]),
         .key_i   (key_q[r-1]),
         .state_o (state_d[r]),
         .key_o   (key_d[r])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= N_R; i++) begin
            state_q[i] <= '0;
            key_q[i]   <= '0;
         end
         vld_q <= '0;
      end else begin
         for (int i = 0; i <= N_R; i++) begin
            state_q[i] <= state_d[i];
            key_q[i]   <= key_d[i];
         end
         vld_q <= vld_d;
      end
   end

   assign c = vld_q[N_R]
            ? (state_q[N_R] ^ key_q[N_R][N_K-1:N_K-N_B])
            : '0;

endmodule

// File: tb/tb_encrypt_pipe.sv
// Scoreboard bench for encrypt_pipe using PRESENT-80 reference vectors.
// Expected ciphertexts are queued at capture and popped at latency.
module tb_encrypt_pipe;
   import encrypt_pipe_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic [N_K-1:0] k;
   logic [N_B-1:0] m;
   logic [N_B-1:0] c;

   int n_err = 0;
   int n_chk = 0;

   logic [N_B-1:0] exp_q [$];

   localparam logic [N_K-1:0] KV [4] = '{
      80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF,
      80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
   localparam logic [N_B-1:0] MV [4] = '{
      64'h0, 64'h0,
      64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
   localparam logic [N_B-1:0] CV [4] = '{
      64'h5579_c138_7b22_8445, 64'he72c_46c0_f594_5049,
      64'ha112_ffc7_2f68_417b, 64'h3333_dcd3_2132_10d2};

   encrypt_pipe u_dut (
      .clk (clk),
      .rst (rst),
      .k   (k),
      .m   (m),
      .c   (c)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [N_B-1:0] got,
                        input logic [N_B-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [N_K-1:0] kk,
                       input logic [N_B-1:0] mm,
                       input logic [N_B-1:0] ce);
      k = kk;
      m = mm;
      @(posedge clk);
      exp_q.push_back(ce);
      #1;
      if (exp_q.size() > N_R)
         check("out", c, exp_q.pop_front());
      else
         check("fill", c, 64'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(80'h0, 64'h0, CV[0]);
   endtask

   initial begin
      rst = 1'b0;
      k   = {16'($urandom), $urandom, $urandom};
      m   = {$urandom, $urandom};
      repeat (5) begin
         @(negedge clk);
         k = {16'($urandom), $urandom, $urandom};
         m = {$urandom, $urandom};
         #1;
         check("rst_hold", c, 64'h0);
      end
      @(negedge clk);
      k   = '0;
      m   = '0;
      rst = 1'b1;
      #1;
      check("release", c, 64'h0);

      idle(40);

      for (int i = 0; i < 4; i++) step(KV[i], MV[i], CV[i]);
      idle(35);

      for (int i = 0; i < 4; i++) step(KV[i], MV[i], CV[i]);
      idle(10);
      for (int i = 0; i < 4; i++) step(KV[i], MV[i], CV[i]);
      idle(20);

      rst = 1'b0;
      #1;
      check("rst_async", c, 64'h0);
      exp_q.delete();
      repeat (2) begin
         @(negedge clk);
         #1;
         check("rst_mid", c, 64'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      step(KV[3], MV[3], CV[3]);
      step(KV[1], MV[1], CV[1]);
      idle(35);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/encrypt_pipe.md
# encrypt_pipe

Fully pipelined PRESENT-80 block-cipher encryption engine: accepts one (key, plaintext) pair per clock and emits one ciphertext per clock after a fixed latency of N_R+1 cycles. Key schedule runs in-pipe alongside the data, so every in-flight block may use a different key. It is the throughput-oriented encryption datapath of the EncryptR design, sitting between the block source and the ciphertext sink with no handshake.

## Interface
- N_K, 80, cipher key width (shared params header)
- N_B, 64, block width (shared params header)
- N_R, 31, number of cipher rounds (shared params header)
- clk  input  1  rising-edge clock (one clock)
- rst  input  1  asynchronous, active-low reset
- k  input  N_K  cipher key for the block presented this cycle
- m  input  N_B  plaintext block presented this cycle
- c  output  N_B  ciphertext of the block presented N_R+1 cycles earlier

## Operation
- Cipher: PRESENT-80. S-box (hex, S[0]..S[F]) = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, applied to all 16 nibbles.
- pLayer: state bit i moves to bit (16*i) mod 63 for i=0..62; bit 63 stays.
- Round r (1..31): state = pLayer(sLayer(state ^ K_r[79:16])).
- Key update producing K_{r+1} from K_r: rotate left 61; bits [79:76] = S(bits [79:76]); bits [19:15] ^= r (5-bit).
- Pipeline: stage 0 registers state0=m, key0=k (=K_1). Stage r (1..31) registers state_r = round_r(state_{r-1}, key_{r-1}) and key_r = update(key_{r-1}, r) (=K_{r+1}).
- Output: c = state_31 ^ key_31[79:16] (final whitening, combinational from stage-31 registers).
- No valid/enable: every stage advances every clock; inputs sampled unconditionally every rising edge.
- X/Z on k or m propagates as X through the corresponding block only; no requirement on its value.

## Timing
- Reset (rst=0, asynchronous): all state and key registers cleared to 0 immediately; c = 0 while in reset and until first real data arrives at stage 31.
- Release of rst is synchronous in effect: first capture on first rising edge with rst=1.
- Latency: (k,m) valid before rising edge t -> c holds its ciphertext from just after edge t+N_R until just after edge t+N_R+1 (32 registers deep).
- Throughput: one block per clock; consecutive blocks independent, arbitrary key per block.
- Reset mid-stream: all in-flight blocks discarded, c returns to 0 at once; resume filling from next edge.
- Back-to-back identical inputs produce identical outputs on consecutive cycles; no inter-block state.

## Structure
- Shared package/header: N_K, N_B, N_R, S-box constant, pLayer permutation function, key-update function.
- One sub-module natural: present_round (inputs state, key, round index constant; outputs next state and next key; purely combinational), instantiated N_R times via generate with registers in encrypt_pipe.
- encrypt_pipe owns all pipeline registers, async reset, and final whitening XOR.

## Test plan
- Reset: hold rst=0 several cycles with random k,m -> c = 0000000000000000 throughout; c stays 0 for 32 edges after release with zero inputs fed.
- Vector k=0, m=0 -> c=5579c1387b228445 exactly 32 edges after capture.
- Vector k=FFFFFFFFFFFFFFFFFFFF, m=0 -> c=e72c46c0f5945049; k=0, m=FFFFFFFFFFFFFFFF -> c=a112ffc72f68417b.
- Vector k=FFFFFFFFFFFFFFFFFFFF, m=FFFFFFFFFFFFFFFF -> c=3333dcd3213210d2.
- Streaming: the four vectors on four consecutive cycles, then idle -> ciphertexts appear in the same order on four consecutive cycles, each at latency 32.
- Reset mid-stream: assert rst=0 with blocks in flight -> c=0 immediately; after release, a fresh vector still yields correct ciphertext at latency 32.
